// File: rtl/stage_mem_pkg.sv
// Shared CPU package: load-type encodings and the load alignment helper used by the MEM stage.
package stage_mem_pkg;

    localparam int MEM_OP_W = 3;

    localparam logic [MEM_OP_W-1:0] LD_W  = 3'd0;
    localparam logic [MEM_OP_W-1:0] LD_B  = 3'd1;
    localparam logic [MEM_OP_W-1:0] LD_H  = 3'd2;
    localparam logic [MEM_OP_W-1:0] LD_BU = 3'd3;
    localparam logic [MEM_OP_W-1:0] LD_HU = 3'd4;

    typedef logic [MEM_OP_W-1:0] mem_op_t;

    // Selects the addressed byte/halfword of a read word and extends it.
    // Reserved codes fall through to a full-word load; a[0] is ignored for halfwords.
    function automatic logic [31:0] load_align(
        input logic [31:0] rdata,
        input logic [1:0]  a,
        input mem_op_t     op
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;
        case (a)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/stage_mem_pipeline.sv
// Common pipeline handshake unit: one valid bit plus allowin/validout/refreshing.
module stage_mem_pipeline (
    input  logic clk,
    input  logic rst,
    input  logic validin,
    input  logic allowout,
    input  logic readygo,
    output logic valid,
    output logic allowin,
    output logic validout,
    output logic refreshing
);

    // Handshake: the stage takes a new instruction from upstream when validin & allowin,
    // and hands its own instruction downstream when validout & allowout. allowin is high
    // whenever the stage is empty or its occupant is leaving this cycle.
    assign allowin    = ~valid | (readygo & allowout);
    assign validout   = valid & readygo;
    assign refreshing = validin & allowin;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (allowin) begin
            valid <= validin;
        end
    end

endmodule

// File: rtl/stage_mem.sv
// MEM stage: captures synchronous SRAM read data, aligns loads, and selects the write-back value.
module stage_mem
    import stage_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        validin,
    input  logic        allowout,
    output logic        allowin,
    output logic        validout,
    input  logic [31:0] input_pc,
    output logic [31:0] output_pc,
    input  logic [4:0]  input_rf_waddr,
    output logic [4:0]  output_rf_waddr,
    input  logic        input_rf_we,
    output logic        output_rf_we,
    input  logic [31:0] input_alu_result,
    input  logic        input_mem_read,
    input  logic [2:0]  input_mem_op,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] output_rf_wdata,
    output logic [31:0] forward_data,
    output logic        forward_we,
    output logic [4:0]  forward_waddr
);

    logic        valid;
    logic        refreshing;

    logic [31:0] pc;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic [31:0] alu_result;
    logic        mem_read;
    mem_op_t     mem_op;

    logic        fresh;
    logic [31:0] rdata_buf;
    logic [31:0] load_word;
    logic [31:0] wdata;

    stage_mem_pipeline u_pipeline (
        .clk        (clk),
        .rst        (rst),
        .validin    (validin),
        .allowout   (allowout),
        .readygo    (1'b1),
        .valid      (valid),
        .allowin    (allowin),
        .validout   (validout),
        .refreshing (refreshing)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= 32'd0;
            rf_waddr   <= 5'd0;
            rf_we      <= 1'b0;
            alu_result <= 32'd0;
            mem_read   <= 1'b0;
            mem_op     <= LD_W;
        end else if (refreshing) begin
            pc         <= input_pc;
            rf_waddr   <= input_rf_waddr;
            rf_we      <= input_rf_we;
            alu_result <= input_alu_result;
            mem_read   <= input_mem_read;
            mem_op     <= input_mem_op;
        end
    end

    // SRAM data is only meaningful in the first cycle after a refresh; buffer it then so
    // a stall survives the SRAM address moving on to EX's next access.
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh     <= 1'b0;
            rdata_buf <= 32'd0;
        end else begin
            fresh <= refreshing & validin;
            if (fresh) begin
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        load_word = fresh ? data_sram_rdata : rdata_buf;
        wdata     = mem_read ? load_align(load_word, alu_result[1:0], mem_op) : alu_result;
    end

    assign output_pc       = pc;
    assign output_rf_waddr = rf_waddr;
    assign output_rf_we    = rf_we;
    assign output_rf_wdata = wdata;
    assign forward_data    = wdata;
    assign forward_we      = valid & rf_we;
    assign forward_waddr   = rf_waddr;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: table of single-instruction vectors plus stall/back-to-back/reset sequences.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        validin;
    logic        allowout;
    logic        allowin;
    logic        validout;
    logic [31:0] input_pc;
    logic [31:0] output_pc;
    logic [4:0]  input_rf_waddr;
    logic [4:0]  output_rf_waddr;
    logic        input_rf_we;
    logic        output_rf_we;
    logic [31:0] input_alu_result;
    logic        input_mem_read;
    logic [2:0]  input_mem_op;
    logic [31:0] data_sram_rdata;
    logic [31:0] output_rf_wdata;
    logic [31:0] forward_data;
    logic        forward_we;
    logic [4:0]  forward_waddr;

    int checks;
    int failures;

    stage_mem dut (
        .clk              (clk),
        .rst              (rst),
        .validin          (validin),
        .allowout         (allowout),
        .allowin          (allowin),
        .validout         (validout),
        .input_pc         (input_pc),
        .output_pc        (output_pc),
        .input_rf_waddr   (input_rf_waddr),
        .output_rf_waddr  (output_rf_waddr),
        .input_rf_we      (input_rf_we),
        .output_rf_we     (output_rf_we),
        .input_alu_result (input_alu_result),
        .input_mem_read   (input_mem_read),
        .input_mem_op     (input_mem_op),
        .data_sram_rdata  (data_sram_rdata),
        .output_rf_wdata  (output_rf_wdata),
        .forward_data     (forward_data),
        .forward_we       (forward_we),
        .forward_waddr    (forward_waddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] alu;
        logic        mem_read;
        logic [2:0]  mem_op;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        exp_fwd_we;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic [4:0] waddr, input logic we,
                               input logic [31:0] alu, input logic mem_read, input logic [2:0] op);
        validin          = 1'b1;
        input_pc         = pc;
        input_rf_waddr   = waddr;
        input_rf_we      = we;
        input_alu_result = alu;
        input_mem_read   = mem_read;
        input_mem_op     = op;
    endtask

    task automatic idle_inputs();
        validin          = 1'b0;
        input_pc         = 32'hFFFF_FFFC;
        input_rf_waddr   = 5'd31;
        input_rf_we      = 1'b1;
        input_alu_result = 32'hA5A5_A5A5;
        input_mem_read   = 1'b1;
        input_mem_op     = LD_B;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        allowout = 1'b1;
        data_sram_rdata = 32'h0;
        idle_inputs();

        //             pc            waddr we alu            rd op     rdata          exp            fwe
        vecs[0]  = '{32'h0000_1000, 5'd5,  1, 32'h1234_5678, 0, LD_W,  32'h0,         32'h1234_5678, 1};
        vecs[1]  = '{32'h0000_1004, 5'd6,  1, 32'h0000_1003, 1, LD_B,  32'h80FF_7F01, 32'hFFFF_FF80, 1};
        vecs[2]  = '{32'h0000_1008, 5'd7,  1, 32'h0000_1003, 1, LD_BU, 32'h80FF_7F01, 32'h0000_0080, 1};
        vecs[3]  = '{32'h0000_100C, 5'd8,  1, 32'h0000_1002, 1, LD_H,  32'h80FF_7F01, 32'hFFFF_80FF, 1};
        vecs[4]  = '{32'h0000_1010, 5'd9,  1, 32'h0000_1000, 1, LD_HU, 32'h80FF_7F01, 32'h0000_7F01, 1};
        vecs[5]  = '{32'h0000_1014, 5'd10, 1, 32'h0000_1001, 1, LD_W,  32'h80FF_7F01, 32'h80FF_7F01, 1};
        vecs[6]  = '{32'h0000_1018, 5'd11, 1, 32'h0000_1001, 1, LD_B,  32'h80FF_7F01, 32'h0000_007F, 1};
        vecs[7]  = '{32'h0000_101C, 5'd12, 1, 32'h0000_1002, 1, LD_B,  32'h80FF_7F01, 32'hFFFF_FFFF, 1};
        vecs[8]  = '{32'h0000_1020, 5'd13, 1, 32'h0000_1003, 1, LD_HU, 32'h80FF_7F01, 32'h0000_80FF, 1};
        vecs[9]  = '{32'h0000_1024, 5'd14, 1, 32'h0000_1001, 1, LD_H,  32'h80FF_7F01, 32'h0000_7F01, 1};
        vecs[10] = '{32'h0000_1028, 5'd15, 1, 32'h0000_1002, 1, 3'd5,  32'h80FF_7F01, 32'h80FF_7F01, 1};
        vecs[11] = '{32'h0000_102C, 5'd16, 1, 32'h0000_1003, 1, 3'd7,  32'h80FF_7F01, 32'h80FF_7F01, 1};
        vecs[12] = '{32'h0000_1030, 5'd17, 0, 32'h0000_1000, 1, LD_B,  32'h80FF_7F81, 32'hFFFF_FF81, 0};
        vecs[13] = '{32'h0000_1034, 5'd18, 1, 32'hCAFE_0001, 0, LD_B,  32'h80FF_7F01, 32'hCAFE_0001, 1};

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        check("reset_validout", {31'd0, validout}, 32'd0);
        check("reset_allowin", {31'd0, allowin}, 32'd1);
        check("reset_forward_we", {31'd0, forward_we}, 32'd0);
        check("reset_wdata", output_rf_wdata, 32'd0);

        // Table vectors: issue, then SRAM returns data the following cycle
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive_instr(vecs[i].pc, vecs[i].waddr, vecs[i].we, vecs[i].alu,
                        vecs[i].mem_read, vecs[i].mem_op);
            @(posedge clk);
            #1;
            idle_inputs();
            data_sram_rdata = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d_wdata", i), output_rf_wdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d_fwd_data", i), forward_data, vecs[i].exp_wdata);
            check($sformatf("vec%0d_fwd_we", i), {31'd0, forward_we}, {31'd0, vecs[i].exp_fwd_we});
            check($sformatf("vec%0d_waddr", i), {27'd0, forward_waddr}, {27'd0, vecs[i].waddr});
            check($sformatf("vec%0d_pc", i), output_pc, vecs[i].pc);
            check($sformatf("vec%0d_validout", i), {31'd0, validout}, 32'd1);
        end

        // Bubble after last vector: valid clears, data registers hold
        @(posedge clk);
        #1 data_sram_rdata = 32'h0BAD_0BAD;
        #1;
        check("bubble_validout", {31'd0, validout}, 32'd0);
        check("bubble_fwd_we", {31'd0, forward_we}, 32'd0);
        check("bubble_wdata_hold", output_rf_wdata, 32'hCAFE_0001);

        // Stall: load 0xDEADBEEF held for 3 cycles while SRAM data changes
        @(negedge clk);
        allowout = 1'b0;
        drive_instr(32'h2000, 5'd3, 1'b1, 32'h0000_0100, 1'b1, LD_W);
        @(posedge clk);
        #1;
        idle_inputs();
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check("stall_first_wdata", output_rf_wdata, 32'hDEAD_BEEF);
        check("stall_first_allowin", {31'd0, allowin}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 data_sram_rdata = 32'h0;
            #1;
            check($sformatf("stall%0d_wdata", c), output_rf_wdata, 32'hDEAD_BEEF);
            check($sformatf("stall%0d_validout", c), {31'd0, validout}, 32'd1);
        end
        @(negedge clk);
        allowout = 1'b1;
        drive_instr(32'h2004, 5'd4, 1'b1, 32'h0000_0104, 1'b1, LD_W);
        @(posedge clk);
        #1;
        idle_inputs();
        data_sram_rdata = 32'h0000_0055;
        #1;
        check("post_stall_wdata", output_rf_wdata, 32'h0000_0055);
        check("post_stall_pc", output_pc, 32'h2004);

        // Back-to-back loads, no bubble
        @(negedge clk);
        drive_instr(32'h3000, 5'd20, 1'b1, 32'h0000_0200, 1'b1, LD_W);
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h0000_0011;
        drive_instr(32'h3004, 5'd21, 1'b1, 32'h0000_0204, 1'b1, LD_W);
        #1;
        check("b2b_first_wdata", output_rf_wdata, 32'h0000_0011);
        check("b2b_first_waddr", {27'd0, forward_waddr}, 32'd20);
        @(posedge clk);
        #1;
        idle_inputs();
        data_sram_rdata = 32'h0000_0022;
        #1;
        check("b2b_second_wdata", output_rf_wdata, 32'h0000_0022);
        check("b2b_second_validout", {31'd0, validout}, 32'd1);
        check("b2b_second_waddr", {27'd0, forward_waddr}, 32'd21);

        // Reset during a stalled load
        @(negedge clk);
        allowout = 1'b0;
        drive_instr(32'h4000, 5'd9, 1'b1, 32'h0000_0300, 1'b1, LD_W);
        @(posedge clk);
        #1;
        idle_inputs();
        data_sram_rdata = 32'h7777_7777;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_stall_validout", {31'd0, validout}, 32'd0);
        check("rst_stall_fwd_we", {31'd0, forward_we}, 32'd0);
        check("rst_stall_allowin", {31'd0, allowin}, 32'd1);
        check("rst_stall_wdata", output_rf_wdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
